imuldiv_muldiv_dispatch: RTL and testbench

Front-end steering stage that sits directly upstream of the iterative multiply and divide units. It accepts a unified muldiv request (fn, a, b) over a val/rdy interface and forwards it to the mul unit or the div unit. It then waits for that unit's response, captures it in a hold register, and returns it to the pipeline over a val/rdy response interface. Only one operation is in flight at a time.

---
 rtl/imuldiv_muldiv_dispatch.sv | 136 +++++++++++++
 tb/tb_imuldiv_muldiv_dispatch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_muldiv_dispatch.sv
// rtl/imuldiv_muldiv_dispatch.sv - steers muldiv requests to the mul or div unit and holds the response
module imuldiv_muldiv_dispatch (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  muldivreq_msg_fn,
   input  logic [31:0] muldivreq_msg_a,
   input  logic [31:0] muldivreq_msg_b,
   input  logic        muldivreq_val,
   output logic        muldivreq_rdy,
   output logic [63:0] muldivresp_msg_result,
   output logic        muldivresp_val,
   input  logic        muldivresp_rdy,
   output logic [31:0] mulreq_msg_a,
   output logic [31:0] mulreq_msg_b,
   output logic        mulreq_val,
   input  logic        mulreq_rdy,
   input  logic [63:0] mulresp_msg_result,
   input  logic        mulresp_val,
   output logic        mulresp_rdy,
   output logic        divreq_msg_fn,
   output logic [31:0] divreq_msg_a,
   output logic [31:0] divreq_msg_b,
   output logic        divreq_val,
   input  logic        divreq_rdy,
   input  logic [63:0] divresp_msg_result,
   input  logic        divresp_val,
   output logic        divresp_rdy
);

   localparam logic [2:0] FN_MUL  = 3'd0;
   localparam logic [2:0] FN_DIV  = 3'd1;
   localparam logic [2:0] FN_DIVU = 3'd2;
   localparam logic [2:0] FN_REMU = 3'd4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MUL = 2'd1,
      WAIT_DIV = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [63:0] hold;
   logic [2:0]  fn_reg;
   logic        fn_is_mul;
   logic        fn_is_div;
   logic        req_fire;
   logic        unit_fire;

   assign fn_is_mul = (muldivreq_msg_fn == FN_MUL);
   assign fn_is_div = (muldivreq_msg_fn >= FN_DIV) && (muldivreq_msg_fn <= FN_REMU);

   // Operands fan out to both units unconditionally; only the val lines steer.
   assign mulreq_msg_a  = muldivreq_msg_a;
   assign mulreq_msg_b  = muldivreq_msg_b;
   assign divreq_msg_a  = muldivreq_msg_a;
   assign divreq_msg_b  = muldivreq_msg_b;
   assign divreq_msg_fn = (muldivreq_msg_fn == FN_DIVU) || (muldivreq_msg_fn == FN_REMU);

   // Response data always comes from the hold register, never straight from a unit.
   assign muldivresp_msg_result = hold;

   assign req_fire  = muldivreq_val & muldivreq_rdy;
   assign unit_fire = (mulresp_val & mulresp_rdy) | (divresp_val & divresp_rdy);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and handshake outputs; each unit is only acknowledged in its own wait state.
   always_comb begin
      state_next     = state;
      muldivreq_rdy  = 1'b0;
      mulreq_val     = 1'b0;
      divreq_val     = 1'b0;
      mulresp_rdy    = 1'b0;
      divresp_rdy    = 1'b0;
      muldivresp_val = 1'b0;
      case (state)
         IDLE: begin
            mulreq_val = muldivreq_val & fn_is_mul;
            divreq_val = muldivreq_val & fn_is_div;
            if (fn_is_mul)
               muldivreq_rdy = mulreq_rdy;
            else if (fn_is_div)
               muldivreq_rdy = divreq_rdy;
            else
               muldivreq_rdy = 1'b1;
            if (req_fire) begin
               if (fn_is_mul)
                  state_next = WAIT_MUL;
               else if (fn_is_div)
                  state_next = WAIT_DIV;
               else
                  state_next = RESP;
            end
         end
         WAIT_MUL: begin
            mulresp_rdy = 1'b1;
            if (mulresp_val)
               state_next = RESP;
         end
         WAIT_DIV: begin
            divresp_rdy = 1'b1;
            if (divresp_val)
               state_next = RESP;
         end
         RESP: begin
            muldivresp_val = 1'b1;
            if (muldivresp_rdy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch fn on accept; capture the owning unit's result, or zero for an illegal op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn_reg <= 3'd0;
         hold   <= 64'd0;
      end else if (req_fire) begin
         fn_reg <= muldivreq_msg_fn;
         if (!fn_is_mul && !fn_is_div)
            hold <= 64'd0;
      end else if (unit_fire) begin
         hold <= (fn_reg == FN_MUL) ? mulresp_msg_result : divresp_msg_result;
      end
   end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb/tb_imuldiv_muldiv_dispatch.sv - directed self-checking bench for imuldiv_muldiv_dispatch
module tb_imuldiv_muldiv_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  muldivreq_msg_fn;
   logic [31:0] muldivreq_msg_a;
   logic [31:0] muldivreq_msg_b;
   logic        muldivreq_val;
   logic        muldivreq_rdy;
   logic [63:0] muldivresp_msg_result;
   logic        muldivresp_val;
   logic        muldivresp_rdy;
   logic [31:0] mulreq_msg_a;
   logic [31:0] mulreq_msg_b;
   logic        mulreq_val;
   logic        mulreq_rdy;
   logic [63:0] mulresp_msg_result;
   logic        mulresp_val;
   logic        mulresp_rdy;
   logic        divreq_msg_fn;
   logic [31:0] divreq_msg_a;
   logic [31:0] divreq_msg_b;
   logic        divreq_val;
   logic        divreq_rdy;
   logic [63:0] divresp_msg_result;
   logic        divresp_val;
   logic        divresp_rdy;

   int total = 0;
   int bad   = 0;

   imuldiv_muldiv_dispatch dut (
      .clk                   (clk),
      .reset                 (reset),
      .muldivreq_msg_fn      (muldivreq_msg_fn),
      .muldivreq_msg_a       (muldivreq_msg_a),
      .muldivreq_msg_b       (muldivreq_msg_b),
      .muldivreq_val         (muldivreq_val),
      .muldivreq_rdy         (muldivreq_rdy),
      .muldivresp_msg_result (muldivresp_msg_result),
      .muldivresp_val        (muldivresp_val),
      .muldivresp_rdy        (muldivresp_rdy),
      .mulreq_msg_a          (mulreq_msg_a),
      .mulreq_msg_b          (mulreq_msg_b),
      .mulreq_val            (mulreq_val),
      .mulreq_rdy            (mulreq_rdy),
      .mulresp_msg_result    (mulresp_msg_result),
      .mulresp_val           (mulresp_val),
      .mulresp_rdy           (mulresp_rdy),
      .divreq_msg_fn         (divreq_msg_fn),
      .divreq_msg_a          (divreq_msg_a),
      .divreq_msg_b          (divreq_msg_b),
      .divreq_val            (divreq_val),
      .divreq_rdy            (divreq_rdy),
      .divresp_msg_result    (divresp_msg_result),
      .divresp_val           (divresp_val),
      .divresp_rdy           (divresp_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      muldivreq_msg_fn = fn;
      muldivreq_msg_a  = a;
      muldivreq_msg_b  = b;
      muldivreq_val    = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd0; muldivreq_msg_b = 32'd0;
      muldivreq_val = 1'b0; muldivresp_rdy = 1'b0;
      mulreq_rdy = 1'b1; mulresp_msg_result = 64'd0; mulresp_val = 1'b0;
      divreq_rdy = 1'b1; divresp_msg_result = 64'd0; divresp_val = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_req_rdy",   {63'd0, muldivreq_rdy},  64'd1);
      chk("rst_resp_val",  {63'd0, muldivresp_val}, 64'd0);
      chk("rst_result",    muldivresp_msg_result,   64'd0);
      chk("rst_unit_rdys", {62'd0, mulresp_rdy, divresp_rdy}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // MUL 6*7, unit answers on the third edge after accept
      req(3'd0, 32'd6, 32'd7);
      #1;
      chk("mul_req_val",  {63'd0, mulreq_val},    64'd1);
      chk("mul_div_val",  {63'd0, divreq_val},    64'd0);
      chk("mul_req_rdy",  {63'd0, muldivreq_rdy}, 64'd1);
      chk("mul_op_a",     {32'd0, mulreq_msg_a},  64'd6);
      chk("mul_op_b",     {32'd0, mulreq_msg_b},  64'd7);
      step();
      muldivreq_val = 1'b0;
      #1;
      chk("wmul_req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
      chk("wmul_resp_rdy",{63'd0, mulresp_rdy},   64'd1);
      chk("wmul_req_val", {63'd0, mulreq_val},    64'd0);
      step();
      chk("wmul_no_val",  {63'd0, muldivresp_val}, 64'd0);
      step();
      mulresp_val = 1'b1; mulresp_msg_result = 64'h2A;
      step();
      mulresp_val = 1'b0; mulresp_msg_result = 64'hDEAD;
      #1;
      chk("mul_resp_val", {63'd0, muldivresp_val}, 64'd1);
      chk("mul_result",   muldivresp_msg_result,   64'h0000_0000_0000_002A);
      muldivresp_rdy = 1'b1;
      step();
      muldivresp_rdy = 1'b0;
      chk("mul_done_val", {63'd0, muldivresp_val}, 64'd0);

      // DIV -7/2 with the div unit initially stalling the request
      req(3'd1, 32'hFFFF_FFF9, 32'd2);
      divreq_rdy = 1'b0;
      #1;
      chk("div_stall_rdy", {63'd0, muldivreq_rdy}, 64'd0);
      chk("div_stall_val", {63'd0, divreq_val},    64'd1);
      step();
      chk("div_stall_idle", {63'd0, divresp_rdy},  64'd0);
      divreq_rdy = 1'b1;
      #1;
      chk("div_fn",    {63'd0, divreq_msg_fn}, 64'd0);
      chk("div_val",   {63'd0, divreq_val},    64'd1);
      chk("div_op_a",  {32'd0, divreq_msg_a},  64'hFFFF_FFF9);
      chk("div_mulv",  {63'd0, mulreq_val},    64'd0);
      step();
      // busy: a new request and a stray mul response must both be refused
      req(3'd0, 32'd1, 32'd1);
      mulresp_val = 1'b1; mulresp_msg_result = 64'h1111;
      #1;
      chk("wdiv_req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
      chk("wdiv_mulv",    {63'd0, mulreq_val},    64'd0);
      chk("wdiv_mul_rdy", {63'd0, mulresp_rdy},   64'd0);
      step();
      mulresp_val = 1'b0; muldivreq_val = 1'b0;
      chk("wdiv_still",   {63'd0, divresp_rdy},    64'd1);
      chk("wdiv_no_val",  {63'd0, muldivresp_val}, 64'd0);
      divresp_val = 1'b1; divresp_msg_result = 64'hFFFF_FFFF_FFFF_FFFD;
      step();
      divresp_val = 1'b0; divresp_msg_result = 64'd0;
      chk("div_resp_val", {63'd0, muldivresp_val}, 64'd1);
      chk("div_result",   muldivresp_msg_result,   64'hFFFF_FFFF_FFFF_FFFD);
      muldivresp_rdy = 1'b1;
      step();
      muldivresp_rdy = 1'b0;

      // illegal fn accepted even with both units stalled; result is zero
      mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
      req(3'd6, 32'd9, 32'd9);
      #1;
      chk("ill_req_rdy", {63'd0, muldivreq_rdy},          64'd1);
      chk("ill_unit_v",  {62'd0, mulreq_val, divreq_val}, 64'd0);
      step();
      muldivreq_val = 1'b0; mulreq_rdy = 1'b1; divreq_rdy = 1'b1;
      chk("ill_resp_val", {63'd0, muldivresp_val}, 64'd1);
      chk("ill_result",   muldivresp_msg_result,   64'd0);
      muldivresp_rdy = 1'b1;
      step();
      muldivresp_rdy = 1'b0;

      // REMU 7%2 with a five-cycle response stall
      req(3'd4, 32'd7, 32'd2);
      #1;
      chk("remu_fn",  {63'd0, divreq_msg_fn}, 64'd1);
      chk("remu_val", {63'd0, divreq_val},    64'd1);
      step();
      muldivreq_val = 1'b0;
      divresp_val = 1'b1; divresp_msg_result = 64'h0000_0001_0000_0003;
      step();
      divresp_val = 1'b0; divresp_msg_result = 64'd0;
      for (int i = 0; i < 5; i++) begin
         chk("remu_hold_val", {63'd0, muldivresp_val}, 64'd1);
         chk("remu_hold_res", muldivresp_msg_result,   64'h0000_0001_0000_0003);
         step();
      end
      muldivresp_rdy = 1'b1;
      req(3'd0, 32'd2, 32'd2);
      #1;
      chk("remu_resp_norq", {63'd0, muldivreq_rdy}, 64'd0);
      step();
      muldivresp_rdy = 1'b0; muldivreq_val = 1'b0;
      chk("remu_idle_rdy", {63'd0, muldivreq_rdy},  64'd1);
      chk("remu_idle_val", {63'd0, muldivresp_val}, 64'd0);

      // reset two cycles into a DIVU
      req(3'd2, 32'd100, 32'd3);
      step();
      muldivreq_val = 1'b0;
      step();
      chk("rdiv_waiting", {63'd0, divresp_rdy}, 64'd1);
      reset = 1'b1;
      #1;
      chk("rdiv_result",  muldivresp_msg_result, 64'd0);
      chk("rdiv_vals",    {61'd0, muldivresp_val, mulreq_val, divreq_val}, 64'd0);
      chk("rdiv_idle",    {63'd0, divresp_rdy},   64'd0);
      chk("rdiv_req_rdy", {63'd0, muldivreq_rdy}, 64'd1);
      step();
      reset = 1'b0;

      // MUL 3*5 after reset
      req(3'd0, 32'd3, 32'd5);
      step();
      muldivreq_val = 1'b0;
      mulresp_val = 1'b1; mulresp_msg_result = 64'd15;
      step();
      mulresp_val = 1'b0; mulresp_msg_result = 64'd0;
      chk("post_rst_val", {63'd0, muldivresp_val}, 64'd1);
      chk("post_rst_mul", muldivresp_msg_result,   64'd15);
      muldivresp_rdy = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1);
   end

endmodule
